pad_io_conditioner: RTL and testbench
=====================================

// Module: pad_io_conditioner
// PURPOSE
//  Parametrised pad-side conditioning stage between the pad ring and the SoC core.
//  - Input path: synchronises and optionally deglitches N_IN asynchronous pad inputs
//    (SPI, UART, JTAG control, fetch enable).
//  - Output path: registers N_OUT core outputs, with a freeze control.
//  - Reset: provides a reset synchroniser for the core.
//  - Sits directly inside the pad instances; replaces the direct pad-to-core wiring.
// PARAMETERS
//  N_IN         14    number of input channels
//  N_OUT        11    number of output channels
//  SYNC_STAGES  2     synchroniser depth, >=2
//  FILT_W       4     filter counter width
//  FILT_CYCLES  8     consecutive stable cycles required to accept a change, 1..2**FILT_W
//  OUT_RST      '0    N_OUT-bit reset value of pad_out_o
// PORTS
//  clk          in   1      core clock, all flops on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  pad_in_i     in   N_IN   raw pad inputs, asynchronous to clk
//  filt_en_i    in   N_IN   per-channel deglitch enable (quasi-static)
//  core_in_o    out  N_IN   conditioned inputs to core
//  rise_o       out  N_IN   1-cycle pulse on 0->1 change of core_in_o
//  fall_o       out  N_IN   1-cycle pulse on 1->0 change of core_in_o
//  core_out_i   in   N_OUT  core outputs toward pads
//  hold_i       in   1      freeze pad_out_o
//  pad_out_o    out  N_OUT  registered outputs to pads
//  rst_sync_n_o out  1      synchronised core reset, async assert / sync deassert
// BEHAVIOUR
//  Reset (rst_n=0, takes effect immediately):
//  - Sync chains, core_in_o, rise_o, fall_o and counters go to 0.
//  - pad_out_o goes to OUT_RST; rst_sync_n_o goes to 0.
//  Synchroniser:
//  - Per channel, SYNC_STAGES flops.
//  - d[i] is the last stage.
//  - No logic is placed between stages.
//  Filter, per channel, evaluated each clk:
//  - filt_en_i[i]=0: core_in_o[i] <= d[i]; cnt[i] <= 0.
//  - filt_en_i[i]=1, d==core_in_o: cnt <= 0.
//  - filt_en_i[i]=1, d!=core_in_o, cnt==FILT_CYCLES-1: core_in_o <= d; cnt <= 0.
//  - filt_en_i[i]=1, d!=core_in_o, otherwise: cnt <= cnt+1.
//  - Any cycle with d==core_in_o during counting restarts the count from 0.
//  - Counter never wraps: at most FILT_CYCLES-1 before the change is accepted.
//  - FILT_CYCLES=1 is identical to unfiltered.
//  - filt_en_i deasserted mid-count: count is discarded and d passes through next edge.
//  Latency, clean pad step just before edge 1:
//  - Unfiltered: core_in_o changes at edge SYNC_STAGES+1.
//  - Filtered: core_in_o changes at edge SYNC_STAGES+FILT_CYCLES.
//  Edges:
//  - rise_o/fall_o are registered together with core_in_o.
//  - High in exactly the first cycle the new value is visible.
//  - Never both high; never high two consecutive cycles on one channel.
//  Output path:
//  - pad_out_o <= hold_i ? pad_out_o : core_out_i.
//  - Latency 1 cycle; hold_i acts per edge; no glitch on release.
//  Reset synchroniser:
//  - SYNC_STAGES-flop chain with input tied 1.
//  - rst_sync_n_o rises at edge SYNC_STAGES after rst_n deasserts.
//  - Falls asynchronously with rst_n.
//  - rst_n reasserted mid-sequence restarts the count.
//  Channels are fully independent; simultaneous changes on all channels are handled in parallel.
// TESTING
//  T1 reset: rst_n=0 mid-run with OUT_RST='h5A5
//     -> all outputs cleared immediately; pad_out_o='h5A5.
//     -> rst_sync_n_o=1 exactly 2 edges after release.
//  T2 unfiltered: filt_en=0, pad_in_i[3] 0->1
//     -> core_in_o[3]=1 and rise_o[3]=1 after edge 3; rise_o[3]=0 after edge 4.
//  T3 glitch reject: filt_en=1, FILT_CYCLES=8, 7-cycle pulse on pad_in_i[4]
//     -> core_in_o[4] stays 0; no edge pulses.
//     -> 8+ cycle pulse -> core_in_o[4]=1 at edge 10 after the step.
//  T4 restart: filt_en=1, pulse 5 cycles high, 1 low, 5 high
//     -> no change.
//     -> drop filt_en during count -> value passes through next edge.
//  T5 hold: core_out_i='h7FF, hold_i=1, then core_out_i='h000
//     -> pad_out_o stays 'h7FF.
//     -> hold_i=0 -> 'h000 one edge later.
//  T6 all 14 inputs toggle same cycle with mixed filt_en
//     -> each channel meets its own latency; rise/fall exclusivity holds (assertion).

Source files
------------

// File: rtl/pad_io_conditioner.sv
// Pad-side conditioning stage: input synchronisers with optional per-channel deglitch
// filters and edge pulses, registered outputs with freeze, and a core reset synchroniser.
module pad_io_conditioner #(
   parameter int unsigned      N_IN        = 14,
   parameter int unsigned      N_OUT       = 11,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter int unsigned      FILT_W      = 4,
   parameter int unsigned      FILT_CYCLES = 8,
   parameter logic [N_OUT-1:0] OUT_RST     = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IN-1:0]  pad_in_i,
   input  logic [N_IN-1:0]  filt_en_i,
   output logic [N_IN-1:0]  core_in_o,
   output logic [N_IN-1:0]  rise_o,
   output logic [N_IN-1:0]  fall_o,
   input  logic [N_OUT-1:0] core_out_i,
   input  logic             hold_i,
   output logic [N_OUT-1:0] pad_out_o,
   output logic             rst_sync_n_o
);

   localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_CYCLES - 1);

   logic [N_IN-1:0]   sync_q [SYNC_STAGES];
   logic [N_IN-1:0]   d;
   logic [FILT_W-1:0] cnt_q  [N_IN];
   logic [FILT_W-1:0] cnt_d  [N_IN];
   logic [N_IN-1:0]   core_d;
   logic [SYNC_STAGES-1:0] rst_chain_q;

   // Plain flop chain, nothing between stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= pad_in_i;
         for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign d = sync_q[SYNC_STAGES-1];

   // A change is accepted only after FILT_CYCLES consecutive differing samples;
   // any agreeing sample restarts the count.
   always_comb begin
      core_d = core_in_o;
      for (int i = 0; i < int'(N_IN); i++) begin
         cnt_d[i] = '0;
         if (!filt_en_i[i]) begin
            core_d[i] = d[i];
         end else if (d[i] != core_in_o[i]) begin
            if (cnt_q[i] == CNT_LAST) core_d[i] = d[i];
            else                      cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_in_o <= '0;
         rise_o    <= '0;
         fall_o    <= '0;
         for (int i = 0; i < int'(N_IN); i++) cnt_q[i] <= '0;
      end else begin
         core_in_o <= core_d;
         rise_o    <= core_d & ~core_in_o;
         fall_o    <= ~core_d & core_in_o;
         for (int i = 0; i < int'(N_IN); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       pad_out_o <= OUT_RST;
      else if (!hold_i) pad_out_o <= core_out_i;
   end

   // Asserts with rst_n, releases after SYNC_STAGES clean edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_chain_q <= '0;
      else        rst_chain_q <= {rst_chain_q[SYNC_STAGES-2:0], 1'b1};
   end

   assign rst_sync_n_o = rst_chain_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_pad_io_conditioner.sv
// Directed bench for pad_io_conditioner: reset, latency, filtering, hold and
// parallel-channel behaviour, with an always-on edge pulse checker.
module tb_pad_io_conditioner;

   localparam int N_IN  = 14;
   localparam int N_OUT = 11;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N_IN-1:0]  pad_in_i;
   logic [N_IN-1:0]  filt_en_i;
   logic [N_IN-1:0]  core_in_o;
   logic [N_IN-1:0]  rise_o;
   logic [N_IN-1:0]  fall_o;
   logic [N_OUT-1:0] core_out_i;
   logic             hold_i;
   logic [N_OUT-1:0] pad_out_o;
   logic             rst_sync_n_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [N_OUT-1:0] exp_q[$];

   pad_io_conditioner #(
      .N_IN(N_IN), .N_OUT(N_OUT), .SYNC_STAGES(2), .FILT_W(4), .FILT_CYCLES(8),
      .OUT_RST(11'h5A5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pad_in_i(pad_in_i), .filt_en_i(filt_en_i),
      .core_in_o(core_in_o), .rise_o(rise_o), .fall_o(fall_o),
      .core_out_i(core_out_i), .hold_i(hold_i), .pad_out_o(pad_out_o),
      .rst_sync_n_o(rst_sync_n_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- driver / check tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- edge pulse monitor ----------------
   logic [N_IN-1:0] prev_rise = '0;
   logic [N_IN-1:0] prev_fall = '0;
   always @(negedge clk) begin
      if (rst_n) begin
         n_checks++;
         if ((rise_o & fall_o) != 0 || (rise_o & prev_rise) != 0 || (fall_o & prev_fall) != 0) begin
            n_fail++;
            $display("FAIL edge_excl: rise %0h fall %0h prev_rise %0h prev_fall %0h",
                     rise_o, fall_o, prev_rise, prev_fall);
         end
         prev_rise = rise_o;
         prev_fall = fall_o;
      end else begin
         prev_rise = '0;
         prev_fall = '0;
      end
   end

   // ---------------- vector tables ----------------
   typedef struct {
      logic        filt;
      logic [31:0] pat;        // bit j drives pad_in_i[4] before edge j+1
      int          first_edge; // edge at which core_in_o[4] first rises, 0 = never
      int          rises;
      int          falls;
   } pulse_vec_t;

   typedef struct {
      logic [N_OUT-1:0] core_out;
      logic             hold;
      logic [N_OUT-1:0] exp;
   } out_vec_t;

   pulse_vec_t pv[6];
   out_vec_t   ov[7];

   initial begin
      pv[0] = '{filt: 1'b0, pat: 32'h1,   first_edge: 3,  rises: 1, falls: 1};
      pv[1] = '{filt: 1'b1, pat: 32'h7F,  first_edge: 0,  rises: 0, falls: 0};
      pv[2] = '{filt: 1'b1, pat: 32'hFF,  first_edge: 10, rises: 1, falls: 1};
      pv[3] = '{filt: 1'b1, pat: 32'h7DF, first_edge: 0,  rises: 0, falls: 0};
      pv[4] = '{filt: 1'b1, pat: 32'hFFF, first_edge: 10, rises: 1, falls: 1};
      pv[5] = '{filt: 1'b0, pat: 32'h5,   first_edge: 3,  rises: 2, falls: 2};

      ov[0] = '{core_out: 11'h7FF, hold: 1'b0, exp: 11'h7FF};
      ov[1] = '{core_out: 11'h000, hold: 1'b1, exp: 11'h7FF};
      ov[2] = '{core_out: 11'h123, hold: 1'b1, exp: 11'h7FF};
      ov[3] = '{core_out: 11'h000, hold: 1'b0, exp: 11'h000};
      ov[4] = '{core_out: 11'h2AA, hold: 1'b0, exp: 11'h2AA};
      ov[5] = '{core_out: 11'h555, hold: 1'b1, exp: 11'h2AA};
      ov[6] = '{core_out: 11'h555, hold: 1'b0, exp: 11'h555};

      // ---- power-on reset ----
      rst_n = 1'b0; pad_in_i = '0; filt_en_i = '0; core_out_i = '0; hold_i = 1'b0;
      #12;
      check("por_core_in", 32'(core_in_o), 32'h0);
      check("por_rise_fall", 32'({rise_o, fall_o}), 32'h0);
      check("por_pad_out", 32'(pad_out_o), 32'h5A5);
      check("por_rst_sync", 32'(rst_sync_n_o), 32'h0);
      rst_n = 1'b1;
      step(); check("rst_rel_edge1", 32'(rst_sync_n_o), 32'h0);
      step(); check("rst_rel_edge2", 32'(rst_sync_n_o), 32'h1);
      step();

      // ---- unfiltered latency on channel 3 ----
      pad_in_i[3] = 1'b1;
      step(); check("unf_edge1", 32'(core_in_o[3]), 32'h0);
      step(); check("unf_edge2", 32'(core_in_o[3]), 32'h0);
      step(); check("unf_edge3_core", 32'(core_in_o[3]), 32'h1);
              check("unf_edge3_rise", 32'(rise_o[3]), 32'h1);
      step(); check("unf_edge4_rise", 32'(rise_o[3]), 32'h0);
              check("unf_edge4_core", 32'(core_in_o[3]), 32'h1);

      // ---- mid-run reset, then reassertion during release ----
      core_out_i = 11'h123;
      step(); check("pre_rst_pad_out", 32'(pad_out_o), 32'h123);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_core_in", 32'(core_in_o), 32'h0);
      check("mid_rst_pad_out", 32'(pad_out_o), 32'h5A5);
      check("mid_rst_sync", 32'(rst_sync_n_o), 32'h0);
      rst_n = 1'b1;
      step(); check("restart_edge1", 32'(rst_sync_n_o), 32'h0);
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      step(); check("restart2_edge1", 32'(rst_sync_n_o), 32'h0);
      step(); check("restart2_edge2", 32'(rst_sync_n_o), 32'h1);
      pad_in_i = '0; core_out_i = '0;
      repeat (5) step();

      // ---- filter pulse table on channel 4 ----
      for (int v = 0; v < 6; v++) begin
         int first, nr, nf;
         first = 0; nr = 0; nf = 0;
         filt_en_i[4] = pv[v].filt;
         for (int k = 1; k <= 40; k++) begin
            pad_in_i[4] = (k <= 32) ? pv[v].pat[k-1] : 1'b0;
            step();
            if (rise_o[4]) begin
               nr++;
               if (first == 0) first = k;
            end
            if (fall_o[4]) nf++;
         end
         check($sformatf("pulse%0d_first_edge", v), 32'(first), 32'(pv[v].first_edge));
         check($sformatf("pulse%0d_rises", v), 32'(nr), 32'(pv[v].rises));
         check($sformatf("pulse%0d_falls", v), 32'(nf), 32'(pv[v].falls));
         check($sformatf("pulse%0d_final", v), 32'(core_in_o[4]), 32'h0);
      end

      // ---- filter disabled mid-count ----
      filt_en_i[4] = 1'b1;
      pad_in_i[4]  = 1'b1;
      repeat (5) step();
      check("drop_filt_before", 32'(core_in_o[4]), 32'h0);
      filt_en_i[4] = 1'b0;
      step();
      check("drop_filt_core", 32'(core_in_o[4]), 32'h1);
      check("drop_filt_rise", 32'(rise_o[4]), 32'h1);
      pad_in_i = '0;
      repeat (5) step();

      // ---- output hold table ----
      for (int v = 0; v < 7; v++) begin
         core_out_i = ov[v].core_out;
         hold_i     = ov[v].hold;
         exp_q.push_back(ov[v].exp);
         step();
         check($sformatf("out_vec%0d", v), 32'(pad_out_o), 32'(exp_q.pop_front()));
      end
      hold_i = 1'b0;

      // ---- all channels toggle together, mixed filtering ----
      filt_en_i = 14'h2AAA;
      repeat (12) step();
      pad_in_i = '1;
      for (int k = 1; k <= 12; k++) begin
         logic [N_IN-1:0] ec, er;
         step();
         ec = (k >= 10) ? 14'h3FFF : (k >= 3) ? 14'h1555 : 14'h0;
         er = (k == 3) ? 14'h1555 : (k == 10) ? 14'h2AAA : 14'h0;
         check($sformatf("par_core_e%0d", k), 32'(core_in_o), 32'(ec));
         check($sformatf("par_rise_e%0d", k), 32'(rise_o), 32'(er));
      end
      pad_in_i = '0;
      for (int k = 1; k <= 12; k++) begin
         logic [N_IN-1:0] ec, ef;
         step();
         ec = (k >= 10) ? 14'h0 : (k >= 3) ? 14'h2AAA : 14'h3FFF;
         ef = (k == 3) ? 14'h1555 : (k == 10) ? 14'h2AAA : 14'h0;
         check($sformatf("par_fcore_e%0d", k), 32'(core_in_o), 32'(ec));
         check($sformatf("par_fall_e%0d", k), 32'(fall_o), 32'(ef));
      end

      // ---- report ----
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
